// File: rtl/axi_fifo_pkg.sv
// Shared helpers for the async AXI FIFO (read and write sides).
// Gray/binary conversion works on a fixed wide vector; callers zero-extend
// their pointer in and truncate the result back (leading zeros do not
// change the conversion of the low bits).
package axi_fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    // Pointer width for a FIFO of 2**addrsize words (one extra wrap bit).
    function automatic int unsigned ptr_width(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_sync_chain.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Ports: clk, rst_n (async active-low), d (source-domain value),
//        q (value after STAGES flops in the clk domain).
module fifo_sync_chain #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/axi_fifo_read_frontend.sv
// Read-clock-domain front end of the async AXI FIFO.
// Synchronizes the write Gray pointer, issues pops to the read-pointer block,
// and turns the raw memory read port into a first-word-fall-through stream
// through a 2-entry (head/skid) buffer. Also reports a registered fill level
// and an almost-empty flag.
// Ports:
//   read_clk, read_rst (async active-low), clear (sync flush)
//   write_ptr_gray -> write_pointer_sync   write pointer crossing
//   read_ptr, empty_read, read_enable      read-pointer block handshake
//   mem_rdata                              combinational memory read data
//   out_data/out_valid/out_ready           output stream
//   fifo_level, almost_empty               registered occupancy status
module axi_fifo_read_frontend
    import axi_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE    = 5,
    parameter int unsigned DATASIZE    = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic                  read_clk,
    input  logic                  read_rst,
    input  logic                  clear,
    input  logic [ADDRSIZE:0]     write_ptr_gray,
    output logic [ADDRSIZE:0]     write_pointer_sync,
    input  logic [ADDRSIZE:0]     read_ptr,
    input  logic                  empty_read,
    output logic                  read_enable,
    input  logic [DATASIZE-1:0]   mem_rdata,
    output logic [DATASIZE-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDRSIZE+1:0]   fifo_level,
    output logic                  almost_empty
);

    localparam int unsigned PW = ptr_width(ADDRSIZE);
    localparam int unsigned LW = ADDRSIZE + 2;

    logic [DATASIZE-1:0] head_q;
    logic [DATASIZE-1:0] tail_q;
    logic [1:0]          cnt_q;

    logic                push_c;
    logic                deq_c;
    logic [1:0]          cnt_next_c;
    logic [PW-1:0]       wr_bin_c;
    logic [PW-1:0]       rd_bin_c;
    logic [PW-1:0]       raw_c;
    logic [LW-1:0]       level_next_c;

    fifo_sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (read_clk),
        .rst_n (read_rst),
        .d     (write_ptr_gray),
        .q     (write_pointer_sync)
    );

    // Pop decision depends only on registered state and clear, never on out_ready.
    assign read_enable = !empty_read && (cnt_q < 2'd2) && !clear;
    assign out_valid   = (cnt_q != 2'd0);
    assign out_data    = head_q;

    // Next occupancy and the level it implies.
    always_comb begin
        push_c       = read_enable;
        deq_c        = out_valid && out_ready;
        cnt_next_c   = cnt_q + 2'(push_c) - 2'(deq_c);
        wr_bin_c     = PW'(gray2bin(GRAY_MAX_W'(write_pointer_sync)));
        rd_bin_c     = PW'(gray2bin(GRAY_MAX_W'(read_ptr)));
        raw_c        = wr_bin_c - rd_bin_c;
        level_next_c = LW'(raw_c) + LW'(cnt_next_c);
    end

    // Head/skid buffer plus registered status; clear discards buffered words.
    always_ff @(posedge read_clk or negedge read_rst) begin
        if (!read_rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= 2'd0;
            fifo_level   <= '0;
            almost_empty <= 1'b1;
        end else if (clear) begin
            cnt_q        <= 2'd0;
            fifo_level   <= '0;
            almost_empty <= 1'b1;
        end else begin
            cnt_q        <= cnt_next_c;
            fifo_level   <= level_next_c;
            almost_empty <= (level_next_c <= LW'(AE_THRESH));
            if (deq_c && (cnt_q == 2'd2)) begin
                head_q <= tail_q;
            end
            // A pop can only happen at cnt 0 or 1, so the tail is never
            // shifting while it is being written.
            if (push_c) begin
                if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && deq_c)) begin
                    head_q <= mem_rdata;
                end else begin
                    tail_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_fifo_read_frontend.sv
// Bench for axi_fifo_read_frontend: behavioural read-pointer block and memory,
// a queue-based reference model checked every cycle, and directed scenarios.
module tb_axi_fifo_read_frontend;
    import axi_fifo_pkg::*;

    localparam int unsigned ADDRSIZE    = 5;
    localparam int unsigned DATASIZE    = 32;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned AE_THRESH   = 4;
    localparam int unsigned PW          = ADDRSIZE + 1;
    localparam int unsigned LW          = ADDRSIZE + 2;
    localparam int unsigned DEPTH       = 1 << ADDRSIZE;

    logic                read_clk = 1'b0;
    logic                read_rst = 1'b0;
    logic                clear = 1'b0;
    logic [PW-1:0]       write_ptr_gray = '0;
    logic [PW-1:0]       write_pointer_sync;
    logic [PW-1:0]       read_ptr;
    logic                empty_read;
    logic                read_enable;
    logic [DATASIZE-1:0] mem_rdata;
    logic [DATASIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LW-1:0]       fifo_level;
    logic                almost_empty;

    int total = 0;
    int bad = 0;
    int delivered = 0;

    axi_fifo_read_frontend #(
        .ADDRSIZE    (ADDRSIZE),
        .DATASIZE    (DATASIZE),
        .SYNC_STAGES (SYNC_STAGES),
        .AE_THRESH   (AE_THRESH)
    ) dut (
        .read_clk           (read_clk),
        .read_rst           (read_rst),
        .clear              (clear),
        .write_ptr_gray     (write_ptr_gray),
        .write_pointer_sync (write_pointer_sync),
        .read_ptr           (read_ptr),
        .empty_read         (empty_read),
        .read_enable        (read_enable),
        .mem_rdata          (mem_rdata),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .fifo_level         (fifo_level),
        .almost_empty       (almost_empty)
    );

    always #5 read_clk = ~read_clk;

    // Environment: FIFO memory and a behavioural read-pointer/empty block.
    logic [DATASIZE-1:0] mem [DEPTH];
    logic [PW-1:0]       rd_bin_env;
    logic [PW-1:0]       wr_bin = '0;

    always_ff @(posedge read_clk or negedge read_rst) begin
        if (!read_rst) begin
            rd_bin_env <= '0;
            empty_read <= 1'b1;
        end else if (clear) begin
            rd_bin_env <= '0;
            empty_read <= 1'b1;
        end else begin
            rd_bin_env <= rd_bin_env + PW'(read_enable);
            empty_read <= (PW'(bin2gray(32'(rd_bin_env + PW'(read_enable)))) == write_pointer_sync);
        end
    end

    assign read_ptr  = PW'(bin2gray(32'(rd_bin_env)));
    assign mem_rdata = mem[rd_bin_env[ADDRSIZE-1:0]];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the output buffer is a queue of at most two words;
    // write_pointer_sync is the write pointer as it was SYNC_STAGES edges ago.
    logic [DATASIZE-1:0] m_q [$];
    logic [DATASIZE-1:0] sb_q [$];
    logic [PW-1:0]       wq [$];
    logic [PW-1:0]       m_wps = '0;
    logic [LW-1:0]       m_level = '0;
    logic                m_ae = 1'b1;
    logic                m_re;
    logic                m_deq;
    logic [PW-1:0]       m_raw;

    always @(negedge read_clk) begin
        if (!read_rst) begin
            m_q.delete();
            sb_q.delete();
            wq.delete();
            for (int i = 0; i < int'(SYNC_STAGES) - 1; i++) wq.push_back('0);
            m_wps   = '0;
            m_level = '0;
            m_ae    = 1'b1;
        end
        m_re = !empty_read && (m_q.size() < 2) && !clear;
        check("m_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("m_data", 64'(out_data), 64'(m_q[0]));
        check("m_level", 64'(fifo_level), 64'(m_level));
        check("m_ae", 64'(almost_empty), 64'(m_ae));
        check("m_wps", 64'(write_pointer_sync), 64'(m_wps));
        check("m_re", 64'(read_enable), 64'(m_re));
        if (read_rst) begin
            m_deq = (m_q.size() != 0) && out_ready && !clear;
            m_raw = PW'(gray2bin(32'(m_wps))) - rd_bin_env;
            if (clear) begin
                m_q.delete();
                sb_q.delete();
                m_level = '0;
                m_ae    = 1'b1;
            end else begin
                if (m_deq) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        check("sb_order", 64'(out_data), 64'(sb_q.pop_front()));
                    end
                    delivered++;
                    void'(m_q.pop_front());
                end
                if (m_re) m_q.push_back(mem_rdata);
                m_level = LW'(m_raw) + LW'(m_q.size());
                m_ae    = (m_level <= LW'(AE_THRESH));
            end
            wq.push_back(write_ptr_gray);
            m_wps = wq.pop_front();
        end
    end

    task automatic tick();
        @(posedge read_clk);
        #2;
    endtask

    task automatic write_word(input logic [DATASIZE-1:0] d);
        mem[wr_bin[ADDRSIZE-1:0]] = d;
        sb_q.push_back(d);
        wr_bin = wr_bin + PW'(1);
        write_ptr_gray = PW'(bin2gray(32'(wr_bin)));
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard = 0;
        while ((out_valid || fifo_level != '0) && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_done", 64'(out_valid || fifo_level != '0), 64'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic re_at3;
        int pops;
        int d0;
        int n_written;
        int max_level;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

        // Reset with a non-zero write pointer held at the input.
        write_ptr_gray = 6'b000011;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_re", 64'(read_enable), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ae", 64'(almost_empty), 64'(1));
        check("rst_wps", 64'(write_pointer_sync), 64'(0));
        read_rst = 1'b1;
        tick();
        check("wps_edge1", 64'(write_pointer_sync), 64'(0));
        tick();
        check("wps_edge2", 64'(write_pointer_sync), 64'(6'b000011));

        // Re-reset with the write pointer at zero.
        read_rst = 1'b0;
        write_ptr_gray = '0;
        wr_bin = '0;
        repeat (3) tick();
        read_rst = 1'b1;
        repeat (2) tick();

        // Single word latency.
        write_word(32'hA5A5_0001);
        lat = 0;
        re_at3 = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 3) re_at3 = read_enable;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        check("single_re_cycle3", 64'(re_at3), 64'(1));
        check("single_latency", 64'(lat), 64'(4));
        check("single_data", 64'(out_data), 64'(32'hA5A5_0001));
        tick();
        check("single_level", 64'(fifo_level), 64'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_taken", 64'(out_valid), 64'(0));

        // Backpressure: four words, only two pops until the consumer is ready.
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) write_word(32'hB000_0000 + 32'(k));
            if (read_enable) pops++;
            tick();
        end
        if (read_enable) pops++;
        check("bp_pops", 64'(pops), 64'(2));
        check("bp_re_off", 64'(read_enable), 64'(0));
        check("bp_level", 64'(fifo_level), 64'(4));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_word", 64'(out_data), 64'(32'hB000_0000 + 32'(k)));
            tick();
        end
        check("bp_empty", 64'(out_valid), 64'(0));
        out_ready = 1'b0;
        repeat (3) tick();

        // almost_empty around the threshold.
        for (int k = 0; k < 12; k++) begin
            if (k < 6) write_word(32'hC000_0000 + 32'(k));
            tick();
        end
        check("ae_level6", 64'(fifo_level), 64'(6));
        check("ae_low", 64'(almost_empty), 64'(0));
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("ae_level4", 64'(fifo_level), 64'(4));
        check("ae_high", 64'(almost_empty), 64'(1));
        drain();

        // Clear while the buffer is full and the consumer is ready.
        for (int k = 0; k < 10; k++) begin
            if (k < 4) write_word(32'hD000_0000 + 32'(k));
            tick();
        end
        check("clr_pre_valid", 64'(out_valid), 64'(1));
        d0 = delivered;
        clear = 1'b1;
        out_ready = 1'b1;
        wr_bin = '0;
        write_ptr_gray = '0;
        #1;
        check("clr_re_off", 64'(read_enable), 64'(0));
        tick();
        check("clr_valid", 64'(out_valid), 64'(0));
        check("clr_level", 64'(fifo_level), 64'(0));
        check("clr_ae", 64'(almost_empty), 64'(1));
        for (int k = 0; k < 3; k++) begin
            check("clr_re_hold", 64'(read_enable), 64'(0));
            tick();
        end
        clear = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("clr_after_valid", 64'(out_valid), 64'(0));
        check("clr_after_level", 64'(fifo_level), 64'(0));
        check("clr_dropped", 64'(delivered), 64'(d0));

        // Wrap: 80 words with random backpressure through a 32-deep FIFO.
        d0 = delivered;
        n_written = 0;
        max_level = 0;
        while (n_written < 80) begin
            if (PW'(wr_bin - rd_bin_env) < PW'(DEPTH)) begin
                write_word(32'hE000_0000 + 32'(n_written));
                n_written++;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        drain();
        check("wrap_count", 64'(delivered - d0), 64'(80));
        check("wrap_max_level", 64'(max_level <= 34), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_fifo_read_frontend.md
Name: axi_fifo_read_frontend

Overview:
Read-clock-domain front end of the async AXI FIFO. It brings the write-domain Gray pointer into read_clk, feeds it to the read-pointer/empty block, and issues pops into that block. It turns the raw FIFO read port into a first-word-fall-through valid/ready stream through a 2-entry output buffer. It also reports a registered read-side fill level and an almost-empty flag.

Parameters:
ADDRSIZE, 5, FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
DATASIZE, 32, data word width.
SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal range 2-4.
AE_THRESH, 4, almost_empty asserts when total level <= AE_THRESH.

Ports:
read_clk  in  1  read-domain clock
read_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous flush, asserted together with the write-side clear
write_ptr_gray  in  ADDRSIZE+1  write pointer, Gray code, write clock domain (asynchronous)
write_pointer_sync  out  ADDRSIZE+1  synchronized Gray write pointer, to the read-pointer block
read_ptr  in  ADDRSIZE+1  registered Gray read pointer, from the read-pointer block
empty_read  in  1  registered empty flag, from the read-pointer block
read_enable  out  1  pop request to the read-pointer block
mem_rdata  in  DATASIZE  FIFO memory data at the current read_addr (combinational read)
out_data  out  DATASIZE  head word of the output stream
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the head word
fifo_level  out  ADDRSIZE+2  words in the FIFO plus words in the output buffer
almost_empty  out  1  fifo_level <= AE_THRESH

Behaviour:
- Reset (read_rst low) clears the sync chain, the output buffer, cnt, out_data and fifo_level to 0, out_valid to 0 and almost_empty to 1. read_enable reads 0 because cnt = 0 and empty_read = 1.
- Synchronizer: SYNC_STAGES flops clocked by read_clk, no logic between stages. write_pointer_sync is the last stage. The chain is not affected by clear.
- Output buffer: 2 entries (head/skid) with occupancy cnt in 0..2.
  - out_valid = (cnt != 0).
  - out_data = head entry, registered; no combinational path from mem_rdata.
- Pop rule: read_enable = !empty_read && cnt < 2 && !clear.
  - No combinational path from out_ready to read_enable.
  - A pop captures mem_rdata into the buffer at the same edge the read pointer advances.
- Per edge:
  - push = read_enable; deq = out_valid && out_ready.
  - cnt_next = cnt + push - deq.
  - Push into an empty buffer, or push with deq at cnt = 1, lands in the head entry. Otherwise the pushed word lands in the tail.
  - On deq with cnt = 2, the tail shifts to the head.
- Throughput: with out_ready held high, steady state is cnt = 1 with one pop and one deq per cycle (100%).
- Latency:
  - write_ptr_gray change to write_pointer_sync: SYNC_STAGES edges.
  - To empty_read low: +1 edge.
  - Pop in that cycle; out_valid high after +1 edge.
  - Total: SYNC_STAGES + 2 edges.
- Level computation:
  - wr_bin = gray2bin(write_pointer_sync); rd_bin = gray2bin(read_ptr).
  - raw = (wr_bin - rd_bin) modulo 2**(ADDRSIZE+1).
  - fifo_level <= raw + cnt_next, registered.
  - almost_empty <= (raw + cnt_next) <= AE_THRESH.
  - Wrap-around of both pointers is handled by the modulo subtraction. raw never exceeds 2**ADDRSIZE.
- clear:
  - Next edge: cnt = 0, out_valid = 0, fifo_level = 0, almost_empty = 1.
  - No pop is issued while clear is high.
  - Buffered words are discarded.
  - The level computation resumes on the first cycle after clear deasserts.
- Clear with a simultaneous out_ready: clear wins, the word is dropped and is not reported as transferred.
- empty_read high with the buffer non-empty: the stream drains normally; no new pops.

Decomposition:
- Package axi_fifo_pkg: gray2bin and bin2gray functions, plus the pointer-width localparam expression (ADDRSIZE+1), shared with the write side.
- One sub-module, fifo_sync_chain (parameters WIDTH, STAGES; async active-low reset). The same module is reused for the read-to-write pointer path.

Test Plan:
- Reset: hold read_rst low with write_ptr_gray = 6'b000011 -> out_valid 0, read_enable 0, fifo_level 0, almost_empty 1, write_pointer_sync 0; after release, write_pointer_sync = 6'b000011 after 2 edges.
- Single word, bench instantiating this block with the read-pointer block, SYNC_STAGES = 2: write_ptr_gray 0 -> 1, mem[0] = 32'hA5A5_0001 -> read_enable high in cycle 3; out_valid with out_data 32'hA5A5_0001 after edge 4; fifo_level = 1.
- Backpressure: 4 words written, out_ready = 0 -> exactly 2 pops, then read_enable stays 0 with cnt = 2 and fifo_level = 4; raise out_ready -> words 0..3 delivered in order on 4 consecutive cycles.
- Wrap: ADDRSIZE = 5, stream 80 incrementing words with out_ready random (50%) -> no loss or duplication, in order, fifo_level never exceeds 34, pointer wrap passes cleanly.
- almost_empty: fill to level 6 with AE_THRESH = 4, out_ready = 0 -> almost_empty 0; dequeue two words -> fifo_level 4 and almost_empty 1 on the edge after the second deq.
- Clear: clear with cnt = 2 and out_ready = 1 -> next edge out_valid 0, fifo_level 0, no read_enable during clear, dropped word not counted.
